// File: rtl/dcache_nway_ctrl.sv
// N-way set-associative write-back / write-allocate data cache with per-set
// round-robin replacement; misses stall the pipeline through a small refill FSM.
module dcache_nway_ctrl #(
  parameter int unsigned WAYS      = 2,
  parameter int unsigned SETS      = 32,
  parameter int unsigned LINE_BITS = 256,
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [ADDR_W-1:0]    p1_addr_i,
  input  logic [DATA_W-1:0]    p1_data_i,
  input  logic                 p1_MemRead_i,
  input  logic                 p1_MemWrite_i,
  output logic [DATA_W-1:0]    p1_data_o,
  output logic                 p1_stall_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i,
  output logic [LINE_BITS-1:0] mem_data_o,
  output logic [ADDR_W-1:0]    mem_addr_o,
  output logic                 mem_enable_o,
  output logic                 mem_write_o
);
  localparam int unsigned OFF_W  = $clog2(LINE_BITS / 8);
  localparam int unsigned IDX_W  = $clog2(SETS);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int unsigned WSEL_W = OFF_W - 2;
  localparam int unsigned PTR_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_REFILL, S_DONE} state_t;
  state_t state_q, state_d;

  logic [WAYS-1:0][SETS-1:0]  valid_q, dirty_q;
  logic [SETS-1:0][PTR_W-1:0] ptr_q;
  logic [TAG_W-1:0]           tag_q  [WAYS][SETS];
  logic [LINE_BITS-1:0]       data_q [WAYS][SETS];
  logic [PTR_W-1:0]           vway_q, vway_d;

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] wsel;
  logic              req, hit, vfound, serviceable, store_hit, refill_done;
  logic [PTR_W-1:0]  hit_way, vway;
  logic [LINE_BITS-1:0] hit_line;
  logic              unused_addr_bits;

  assign idx              = p1_addr_i[OFF_W +: IDX_W];
  assign req_tag          = p1_addr_i[ADDR_W-1 -: TAG_W];
  assign wsel             = p1_addr_i[OFF_W-1:2];
  assign unused_addr_bits = ^p1_addr_i[1:0];
  assign req              = p1_MemRead_i | p1_MemWrite_i;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[w][idx] && (tag_q[w][idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = PTR_W'(w);
      end
    end
  end

  // Lowest-index invalid way wins; a full set falls back to its round-robin pointer.
  always_comb begin
    vfound = 1'b0;
    vway   = ptr_q[idx];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!vfound && !valid_q[w][idx]) begin
        vfound = 1'b1;
        vway   = PTR_W'(w);
      end
    end
  end

  assign serviceable = (state_q == S_IDLE) || (state_q == S_DONE);
  assign store_hit   = p1_MemWrite_i && hit && serviceable;
  assign refill_done = (state_q == S_REFILL) && mem_ack_i;
  assign hit_line    = data_q[hit_way][idx];
  assign p1_data_o   = (hit && serviceable) ? hit_line[int'(wsel) * DATA_W +: DATA_W] : '0;
  assign p1_stall_o  = !rst_i && ((state_q == S_WRITEBACK) || (state_q == S_REFILL) ||
                                  (req && !hit));
  assign vway_d      = (state_q == S_IDLE) ? vway : vway_q;

  always_comb begin
    state_d      = state_q;
    mem_enable_o = 1'b0;
    mem_write_o  = 1'b0;
    mem_addr_o   = '0;
    mem_data_o   = '0;
    case (state_q)
      S_IDLE: begin
        if (req && !hit)
          state_d = (valid_q[vway][idx] && dirty_q[vway][idx]) ? S_WRITEBACK : S_REFILL;
      end
      S_WRITEBACK: begin
        mem_enable_o = 1'b1;
        mem_write_o  = 1'b1;
        mem_addr_o   = {tag_q[vway_q][idx], idx, {OFF_W{1'b0}}};
        mem_data_o   = data_q[vway_q][idx];
        if (mem_ack_i) state_d = S_REFILL;
      end
      S_REFILL: begin
        mem_enable_o = 1'b1;
        mem_addr_o   = {req_tag, idx, {OFF_W{1'b0}}};
        if (mem_ack_i) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      valid_q <= '0;
      dirty_q <= '0;
      ptr_q   <= '0;
      vway_q  <= '0;
    end else begin
      state_q <= state_d;
      vway_q  <= vway_d;
      if (refill_done) begin
        valid_q[vway_q][idx] <= 1'b1;
        dirty_q[vway_q][idx] <= 1'b0;
        if ((WAYS > 1) && valid_q[vway_q][idx]) ptr_q[idx] <= ptr_q[idx] + 1'b1;
      end
      if (store_hit) dirty_q[hit_way][idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk_i) begin
    if (refill_done) begin
      tag_q[vway_q][idx]  <= req_tag;
      data_q[vway_q][idx] <= mem_data_i;
    end else if (store_hit) begin
      data_q[hit_way][idx][int'(wsel) * DATA_W +: DATA_W] <= p1_data_i;
    end
  end
endmodule

// File: tb/tb_dcache_nway_ctrl.sv
// Directed + randomized bench for dcache_nway_ctrl with a behavioural cache and
// memory model; the bench also acts as the external memory.
module tb_dcache_nway_ctrl;
  localparam int unsigned WAYS = 2;
  localparam int unsigned SETS = 32;
  localparam int unsigned LB   = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   addr = '0, din = '0, dout, mem_addr;
  logic          rd = 1'b0, wr = 1'b0, stall, ack = 1'b0, mem_en, mem_wr;
  logic [LB-1:0] mem_din = '0, mem_dout;

  always #5 clk = ~clk;

  dcache_nway_ctrl #(.WAYS(WAYS), .SETS(SETS), .LINE_BITS(LB), .ADDR_W(32), .DATA_W(32)) dut (
    .clk_i(clk), .rst_i(rst), .p1_addr_i(addr), .p1_data_i(din),
    .p1_MemRead_i(rd), .p1_MemWrite_i(wr), .p1_data_o(dout), .p1_stall_o(stall),
    .mem_data_i(mem_din), .mem_ack_i(ack), .mem_data_o(mem_dout), .mem_addr_o(mem_addr),
    .mem_enable_o(mem_en), .mem_write_o(mem_wr)
  );

  int checks = 0, errors = 0;
  int fixed_delay = -1;
  bit            mv [WAYS][SETS];
  bit            md [WAYS][SETS];
  int unsigned   mt [WAYS][SETS];
  logic [LB-1:0] ml [WAYS][SETS];
  int unsigned   mptr [SETS];
  logic [LB-1:0] mem [int unsigned];

  task automatic chk(input string tag, input logic [LB-1:0] obs, input logic [LB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [LB-1:0] mem_line(input int unsigned la);
    logic [LB-1:0] l;
    if (mem.exists(la)) return mem[la];
    for (int i = 0; i < 8; i++) l[i*32 +: 32] = (la + 32'(i) * 4) ^ 32'hC0DE_0000;
    return l;
  endfunction

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        mv[w][s] = 1'b0;
        md[w][s] = 1'b0;
      end
    for (int s = 0; s < SETS; s++) mptr[s] = 0;
  endtask

  task automatic advance();
    @(negedge clk);
    ack = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rd  = 1'b0;
    wr  = 1'b0;
    repeat (3) advance();
    model_reset();
    rst = 1'b0;
  endtask

  task automatic serve(input bit wb, input int unsigned ea, input logic [LB-1:0] ed);
    int d;
    d = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 4));
    for (int c = 0; c <= d; c++) begin
      advance();
      chk("mem_enable", {255'd0, mem_en}, 1);
      chk("mem_write", {255'd0, mem_wr}, {255'd0, wb});
      chk("mem_addr", {224'd0, mem_addr}, {224'd0, ea});
      chk("stall_busy", {255'd0, stall}, 1);
      if (wb) chk("wb_data", mem_dout, ed);
      if (c == d) begin
        if (!wb) mem_din = mem_line(ea);
        ack = 1'b1;
      end
    end
  endtask

  task automatic access(input int unsigned a, input bit st, input logic [31:0] wd);
    int unsigned s, t, wi, la;
    int hw, v;
    s  = (a >> 5) % SETS;
    t  = a >> 10;
    wi = (a >> 2) % 8;
    hw = -1;
    v  = -1;
    advance();
    addr = a; din = wd; rd = !st; wr = st;
    #1;
    for (int w = 0; w < WAYS; w++) if (mv[w][s] && mt[w][s] == t) hw = w;
    if (hw < 0) begin
      chk("stall_on_miss", {255'd0, stall}, 1);
      chk("idle_enable", {255'd0, mem_en}, 0);
      for (int w = 0; w < WAYS; w++) if (v < 0 && !mv[w][s]) v = w;
      if (v < 0) v = int'(mptr[s]);
      if (mv[v][s] && md[v][s]) begin
        la = (mt[v][s] << 10) | (s << 5);
        serve(1'b1, la, ml[v][s]);
        mem[la] = ml[v][s];
      end
      serve(1'b0, a & ~32'd31, '0);
      if (mv[v][s]) mptr[s] = (mptr[s] + 1) % WAYS;
      mv[v][s] = 1'b1;
      md[v][s] = 1'b0;
      mt[v][s] = t;
      ml[v][s] = mem_line(a & ~32'd31);
      advance();
      hw = v;
    end
    chk("stall_on_service", {255'd0, stall}, 0);
    chk("enable_on_service", {255'd0, mem_en}, 0);
    if (st) begin
      ml[hw][s][wi*32 +: 32] = wd;
      md[hw][s] = 1'b1;
    end else begin
      chk("load_data", {224'd0, dout}, {224'd0, ml[hw][s][wi*32 +: 32]});
    end
    @(posedge clk);
    #1;
    rd = 1'b0;
    wr = 1'b0;
  endtask

  task automatic probe(input int unsigned a, input bit exp_hit);
    advance();
    addr = a; rd = 1'b1; wr = 1'b0;
    #1;
    chk("probe_stall", {255'd0, stall}, {255'd0, !exp_hit});
    rd = 1'b0;
    #1;
  endtask

  initial begin
    int unsigned a;
    model_reset();
    #2;
    chk("rst_stall", {255'd0, stall}, 0);
    chk("rst_enable", {255'd0, mem_en}, 0);
    chk("rst_write", {255'd0, mem_wr}, 0);
    chk("rst_addr", {224'd0, mem_addr}, 0);
    chk("rst_wbdata", mem_dout, 0);
    chk("rst_dout", {224'd0, dout}, 0);
    do_reset();

    // cold miss with a slow refill, then a same-line hit
    fixed_delay = 10;
    access(32'h400, 1'b0, '0);
    fixed_delay = -1;
    access(32'h404, 1'b0, '0);

    // store hit, then two conflicting loads force a dirty writeback of 0x400
    access(32'h400, 1'b1, 32'hDEAD_BEEF);
    access(32'h1400, 1'b0, '0);
    access(32'h2400, 1'b0, '0);
    probe(32'h400, 1'b0);
    probe(32'h1400, 1'b1);

    // round-robin: A,B fill set 0, C replaces way 0, D replaces way 1
    do_reset();
    access(32'h000, 1'b0, '0);
    access(32'h400, 1'b0, '0);
    access(32'h800, 1'b0, '0);
    access(32'hC00, 1'b0, '0);
    probe(32'h800, 1'b1);
    probe(32'hC00, 1'b1);
    probe(32'h000, 1'b0);
    probe(32'h400, 1'b0);

    // reset in the middle of a refill
    advance();
    addr = 32'h1000; rd = 1'b1; wr = 1'b0;
    advance();
    advance();
    chk("refill_enable", {255'd0, mem_en}, 1);
    rst = 1'b1;
    #1;
    chk("rst_mid_enable", {255'd0, mem_en}, 0);
    chk("rst_mid_stall", {255'd0, stall}, 0);
    rd = 1'b0;
    advance();
    rst = 1'b0;
    model_reset();
    access(32'h800, 1'b0, '0);
    access(32'h1000, 1'b0, '0);

    // spurious ack while idle must be ignored
    advance();
    mem_din = {8{32'hBAD0_BAD0}};
    ack = 1'b1;
    #1;
    chk("spur_stall", {255'd0, stall}, 0);
    chk("spur_enable", {255'd0, mem_en}, 0);
    advance();
    chk("spur_enable_after", {255'd0, mem_en}, 0);
    access(32'h800, 1'b0, '0);
    access(32'h1004, 1'b0, '0);

    // randomized traffic over a few conflicting tags and sets
    for (int i = 0; i < 200; i++) begin
      a = ($urandom_range(0, 5) << 10) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
      access(a, 1'($urandom_range(0, 1)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
